left_shift_seq: RTL

LEFT_SHIFT_SEQ -- requirements
Module: left_shift_seq

---
 rtl/left_shift_seq_if.sv | 41 ++++
 rtl/left_shift_seq.sv | 97 +++++++++
 2 files changed

// File: rtl/left_shift_seq_if.sv
// ---------------------------------------------------------------------------
// left_shift_seq_if
// Request/result bundle for the sequential left shifter.
//
// Handshake: a request is accepted on a rising clk edge where start=1 and
// ready=1. A and shamt are captured only at that edge. ready, busy and done
// are mutually exclusive status flags. done pulses for exactly one cycle.
// B/carry/ovf are valid while done=1 and hold until the next acceptance.
//
// Signals
//   start  requester -> shifter  request strobe
//   A      requester -> shifter  32-bit operand
//   shamt  requester -> shifter  5-bit shift amount (0..31)
//   ready  shifter -> requester  idle, can accept
//   busy   shifter -> requester  shifting
//   done   shifter -> requester  one-cycle completion pulse
//   B      shifter -> requester  working/result register
//   carry  shifter -> requester  last bit shifted out of bit 31
//   ovf    shifter -> requester  OR of all bits shifted out of bit 31
// ---------------------------------------------------------------------------
interface left_shift_seq_if;
    logic        start;
    logic [31:0] A;
    logic [4:0]  shamt;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] B;
    logic        carry;
    logic        ovf;

    modport master (
        output start, A, shamt,
        input  ready, busy, done, B, carry, ovf
    );

    modport slave (
        input  start, A, shamt,
        output ready, busy, done, B, carry, ovf
    );
endinterface

// File: rtl/left_shift_seq.sv
// ---------------------------------------------------------------------------
// left_shift_seq
// Sequential 32-bit logical left shifter, one bit per clock.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   bus        left_shift_seq_if.slave (start/A/shamt in, status/result out)
//   state_dbg  current FSM state (0=IDLE, 1=SHIFT, 2=DONE) for observation
//
// Operation: on acceptance B<=A and the remaining count <=shamt. Each SHIFT
// cycle moves B left by one, recording the bit leaving bit 31 in carry and
// OR-ing it into ovf. shamt=0 goes straight to DONE. DONE lasts one cycle
// and always returns to IDLE. Reset wins over everything, including a start
// presented on the same edge.
// ---------------------------------------------------------------------------
module left_shift_seq (
    input  logic                 clk,
    input  logic                 rst_n,
    left_shift_seq_if.slave      bus,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  cnt;

    assign state_dbg = state;

    // Status flags are registered alongside the state so they always change
    // on the same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            bus.B     <= 32'd0;
            bus.carry <= 1'b0;
            bus.ovf   <= 1'b0;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.B     <= bus.A;
                        cnt       <= bus.shamt;
                        bus.carry <= 1'b0;
                        bus.ovf   <= 1'b0;
                        bus.ready <= 1'b0;
                        if (bus.shamt != 5'd0) begin
                            state    <= SHIFT;
                            bus.busy <= 1'b1;
                            bus.done <= 1'b0;
                        end else begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end
                    end
                end

                SHIFT: begin
                    bus.B     <= {bus.B[30:0], 1'b0};
                    bus.carry <= bus.B[31];
                    bus.ovf   <= bus.ovf | bus.B[31];
                    cnt       <= cnt - 5'd1;
                    // cnt==1 means this edge performs the last shift.
                    if (cnt == 5'd1) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    bus.done  <= 1'b0;
                    bus.ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                    bus.busy  <= 1'b0;
                    bus.done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
